// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter that feeds a shared 3-to-8 select path with a registered owner index.
// Optional tenure limit compiled in with `define ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_decode_arbiter #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o,
  output logic             timeout_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  if (N_REQ != 8 || IDX_W != 3 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : gBadParam
    $error("rr_decode_arbiter: unsupported parameter combination");
  end

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   gntIdx_q, gntIdx_d;
  logic               gntVld_q, gntVld_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [IDX_W-1:0]   winIdx;
  logic [IDX_W-1:0]   candIdx;
  logic               winFound;

  // Scan from the priority pointer upward; the 3-bit sum wraps naturally modulo 8.
  always_comb begin
    winIdx   = ptr_q;
    candIdx  = ptr_q;
    winFound = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      candIdx = ptr_q + IDX_W'(i);
      if (!winFound && req_i[candIdx]) begin
        winIdx   = candIdx;
        winFound = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] holdCnt_q, holdCnt_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gntIdx_d = gntIdx_q;
    gntVld_d = gntVld_q;
    ptr_d    = ptr_q;
`ifdef ARB_TIMEOUT_EN
    holdCnt_d = holdCnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en_i && winFound) begin
          state_d  = GRANT;
          gntIdx_d = winIdx;
          gnt_d    = N_REQ'(1) << winIdx;
          gntVld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          holdCnt_d = 8'd0;
`endif
        end
      end
      GRANT: begin
        // A normal release wins over a tenure revoke landing on the same edge.
        if (!req_i[gntIdx_q]) begin
          state_d  = IDLE;
          gnt_d    = '0;
          gntVld_d = 1'b0;
          ptr_d    = gntIdx_q + IDX_W'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (holdCnt_q == 8'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gntVld_d  = 1'b0;
          ptr_d     = gntIdx_q + IDX_W'(1);
          timeout_d = 1'b1;
        end else begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gntVld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gntIdx_q <= '0;
      gntVld_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gntIdx_q <= gntIdx_d;
      gntVld_q <= gntVld_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      holdCnt_q <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gntIdx_q;
  assign gnt_vld_o = gntVld_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Randomized and directed bench for rr_decode_arbiter against a cycle-level ownership model.
// Honours `define ARB_TIMEOUT_EN the same way as the design, with a tenure limit of 4.
module tb_rr_decode_arbiter;

  localparam int MaxHold = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gntIdx;
  logic       gntVld;
  logic       timeout;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: owner is -1 when nobody holds the resource.
  int owner   = -1;
  int ptr     = 0;
  int lastIdx = 0;
  int hold    = 0;
  bit toExp   = 1'b0;

  rr_decode_arbiter #(
    .N_REQ   (8),
    .IDX_W   (3),
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .req_i    (req),
    .gnt_o    (gnt),
    .gnt_idx_o(gntIdx),
    .gnt_vld_o(gntVld),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Advance the ownership model by one rising edge using the sampled inputs.
  task automatic modelStep(input bit r, input bit e, input logic [7:0] q);
    bit found;
    int c;
    toExp = 1'b0;
    if (r) begin
      owner = -1; ptr = 0; lastIdx = 0; hold = 0;
    end else if (owner < 0) begin
      found = 1'b0;
      if (e && q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          c = (ptr + k) % 8;
          if (!found && q[c]) begin
            found = 1'b1; owner = c; lastIdx = c; hold = 0;
          end
        end
      end
    end else if (!q[owner]) begin
      ptr = (owner + 1) % 8; owner = -1;
    end else if (TimeoutOn && hold == MaxHold - 1) begin
      ptr = (owner + 1) % 8; owner = -1; toExp = 1'b1;
    end else begin
      hold++;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs against the model.
  task automatic applyStimulus(input bit r, input bit e, input logic [7:0] q);
    rst = r; en = e; req = q;
    @(posedge clk);
    modelStep(r, e, q);
    #1;
    checkOutput("gnt",     32'(gnt),     (owner >= 0) ? (32'd1 << owner) : 32'd0);
    checkOutput("gntVld",  32'(gntVld),  (owner >= 0) ? 32'd1 : 32'd0);
    checkOutput("gntIdx",  32'(gntIdx),  32'(lastIdx));
    checkOutput("timeout", 32'(timeout), 32'(toExp));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rq;
    rst = 1'b1; en = 1'b0; req = 8'h00;

    // Reset with all requests high, then first grant to index 0.
    applyStimulus(1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("rstGnt", 32'(gnt), 32'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("firstGnt", 32'(gnt), 32'h01);

    // Rotation through all eight owners with a bubble between each.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF);
      applyStimulus(1'b0, 1'b1, 8'hFF);
      rq = 8'hFF; rq[k] = 1'b0;
      applyStimulus(1'b0, 1'b1, rq);
      checkOutput("rotBubble", 32'(gntVld), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'hFF);
      checkOutput("rotGnt", 32'(gnt), 32'd1 << ((k + 1) % 8));
    end
    applyStimulus(1'b0, 1'b1, 8'h00);

    // Wrap: park the pointer at 6, then the search must wrap to 0 then 2.
    applyStimulus(1'b0, 1'b1, 8'h20);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h05);
    checkOutput("wrapGnt0", 32'(gnt), 32'h01);
    applyStimulus(1'b0, 1'b1, 8'h04);
    applyStimulus(1'b0, 1'b1, 8'h04);
    checkOutput("wrapGnt2", 32'(gnt), 32'h04);
    applyStimulus(1'b0, 1'b1, 8'h00);

    // Enable gating, then en dropped while the grant is held.
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 8'h10);
    checkOutput("gateIdle", 32'(gntVld), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h10);
    checkOutput("gateGnt", 32'(gnt), 32'h10);
    applyStimulus(1'b0, 1'b0, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("gateRel", 32'(gntVld), 32'd0);

    // Reset in the middle of a grant to index 3.
    applyStimulus(1'b0, 1'b1, 8'h08);
    checkOutput("midGnt3", 32'(gntIdx), 32'd3);
    applyStimulus(1'b1, 1'b1, 8'h08);
    checkOutput("midRst", 32'(gntVld), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h09);
    checkOutput("midAfter", 32'(gnt), 32'h01);
    applyStimulus(1'b0, 1'b1, 8'h00);

    // Constant requests from 0 and 1: tenure limit exercise (or unlimited hold).
    for (int k = 0; k < 14; k++) applyStimulus(1'b0, 1'b1, 8'h03);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);

    // Randomized traffic; the owner usually keeps its request high.
    for (int n = 0; n < 600; n++) begin
      rq = 8'($urandom);
      if (owner >= 0 && $urandom_range(7, 0) != 0) rq[owner] = 1'b1;
      applyStimulus($urandom_range(49, 0) == 0, $urandom_range(3, 0) != 0, rq);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
